slice_adder: RTL and testbench

Parametrised multi-cycle two's-complement adder/subtractor with carry and signed-overflow flags. It processes `SLICE` bits per clock through one `SLICE`-bit carry chain, so a wide add costs area proportional to `SLICE` rather than `WIDTH`. Operands enter and results leave through valid/ready handshakes. It sits in the datapath as the next-generation replacement for the fixed 16-bit combinational adder wherever width must scale or subtraction is needed.

---
 rtl/slice_adder.sv | 140 ++++++++++++++
 tb/tb_slice_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_adder.sv
`timescale 1ns/1ps
// slice_adder: multi-cycle two's-complement adder/subtractor. SLICE bits are
// summed per clock through one SLICE-bit carry chain, N = WIDTH/SLICE clocks per op.
module slice_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovfl,
    output logic [1:0]       o_dbg_state
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovfl;
    logic [IDX_W-1:0] r_idx;

    logic [31:0]      w_base;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE:0]   w_slice_sum;
    logic             w_msb_carry_in;
    logic             w_last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE, out_valid only in DONE; the
    // result is held unchanged in DONE until out_ready is seen.
    assign w_base    = 32'(r_idx) * 32'(SLICE);
    assign w_a_slice = r_a[w_base +: SLICE];
    assign w_b_slice = r_b[w_base +: SLICE];
    assign w_last    = (r_idx == LAST_IDX);

    assign w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, r_carry};

    // The carry into the slice MSB is recovered from the MSB sum bit.
    assign w_msb_carry_in = w_a_slice[SLICE-1] ^ w_b_slice[SLICE-1] ^ w_slice_sum[SLICE-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovfl  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_s[w_base +: SLICE] <= w_slice_sum[SLICE-1:0];
                    r_carry              <= w_slice_sum[SLICE];
                    if (w_last) begin
                        r_cout <= w_slice_sum[SLICE];
                        r_ovfl <= w_msb_carry_in ^ w_slice_sum[SLICE];
                    end else begin
                        // idx stops at the last slice; only a new accept clears it.
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s           = r_s;
    assign cout        = r_cout;
    assign ovfl        = r_ovfl;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_slice_adder.sv
`timescale 1ns/1ps
// Bench for slice_adder: four configurations run side by side, each with its own
// reset, driver, expected queue and monitor, against an arithmetic a +/- b model.
module tb_slice_adder;

    localparam int NCFG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 16 : (g == 1) ? 16 : (g == 2) ? 32 : 24;
        localparam int SL = (g == 0) ? 4  : (g == 1) ? 16 : (g == 2) ? 1  : 8;
        localparam int N  = W / SL;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic         sub;
        logic         out_valid;
        logic         out_ready;
        logic         cout;
        logic         ovfl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic [1:0]   dbg_state;

        logic [W+1:0] exp_q[$];
        int           acc_q[$];
        int           hold_q[$];

        slice_adder #(.WIDTH(W), .SLICE(SL)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .a          (a),
            .b          (b),
            .sub        (sub),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .s          (s),
            .cout       (cout),
            .ovfl       (ovfl),
            .o_dbg_state(dbg_state)
        );

        // Reference: integer a+b or a-b; flags from unsigned range and signed range.
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic op);
            longint lim, ux, uy, sx, sy, full, sres;
            logic [W-1:0] rs;
            logic c, v;
            lim = longint'(1) << W;
            ux = longint'(x);
            uy = longint'(y);
            sx = x[W-1] ? ux - lim : ux;
            sy = y[W-1] ? uy - lim : uy;
            if (op) begin
                full = ux - uy;
                c    = (ux >= uy);
                sres = sx - sy;
            end else begin
                full = ux + uy;
                c    = (full >= lim);
                sres = sx + sy;
            end
            rs = W'(full);
            v  = (sres >= lim / 2) || (sres < -(lim / 2));
            return {v, c, rs};
        endfunction

        function automatic logic [W-1:0] rand_op();
            logic [W-1:0] r;
            r = W'($urandom);
            case ($urandom_range(0, 7))
                0: r = '0;
                1: r = '1;
                2: r = {1'b1, {(W-1){1'b0}}};
                3: r = {1'b0, {(W-1){1'b1}}};
                default: begin
                end
            endcase
            return r;
        endfunction

        // Called at a falling edge; toggles junk inputs while busy, then issues one op.
        task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                             input int hold);
            int guard;
            guard = 0;
            while (!(in_ready && rst_n)) begin
                a        = W'($urandom);
                b        = W'($urandom);
                sub      = 1'($urandom_range(0, 1));
                in_valid = rst_n && ($urandom_range(0, 1) == 1);
                @(negedge clk);
                guard++;
                if (guard > 200) begin
                    check($sformatf("cfg%0d in_ready timeout", g), 64'(in_ready), 64'd1);
                    in_valid = 1'b0;
                    return;
                end
            end
            a        = ta;
            b        = tb_v;
            sub      = ts;
            in_valid = 1'b1;
            exp_q.push_back(model(ta, tb_v, ts));
            acc_q.push_back(cyc + 1);
            hold_q.push_back(hold);
            @(negedge clk);
            in_valid = 1'b0;
        endtask

        task automatic drain();
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("cfg%0d drain", g), 64'(exp_q.size()), 64'd0);
        endtask

        initial begin : mon
            logic         prev_v;
            logic         expect_idle;
            logic [W+1:0] cur;
            int           hold_left;
            int           lat;
            prev_v      = 1'b0;
            expect_idle = 1'b0;
            cur         = '0;
            hold_left   = 0;
            out_ready   = 1'b0;
            forever begin
                @(negedge clk);
                #1;
                if (!rst_n) begin
                    exp_q.delete();
                    acc_q.delete();
                    hold_q.delete();
                    prev_v      = 1'b0;
                    expect_idle = 1'b0;
                    out_ready   = 1'b0;
                end else begin
                    if (expect_idle) begin
                        check($sformatf("cfg%0d idle after accept", g),
                              64'({out_valid, in_ready}), 64'b01);
                        expect_idle = 1'b0;
                    end
                    if (out_valid) begin
                        if (!prev_v) begin
                            if (exp_q.size() == 0) begin
                                check($sformatf("cfg%0d unexpected out_valid", g),
                                      64'(out_valid), 64'd0);
                                hold_left = 0;
                            end else begin
                                cur       = exp_q.pop_front();
                                lat       = cyc - acc_q.pop_front();
                                hold_left = hold_q.pop_front();
                                check($sformatf("cfg%0d result {ovfl,cout,s}", g),
                                      64'({ovfl, cout, s}), 64'(cur));
                                check($sformatf("cfg%0d latency", g), 64'(lat), 64'(N));
                            end
                        end else begin
                            check($sformatf("cfg%0d held result", g), 64'({ovfl, cout, s}), 64'(cur));
                            check($sformatf("cfg%0d in_ready in done", g), 64'(in_ready), 64'd0);
                        end
                        out_ready = (hold_left == 0);
                        if (hold_left > 0) hold_left--;
                        expect_idle = out_ready;
                    end else begin
                        out_ready = 1'b0;
                    end
                    prev_v = out_valid;
                end
            end
        end

        initial begin : drv
            logic [31:0] dir_a [6];
            logic [31:0] dir_b [6];
            logic        dir_s [6];
            int          dir_h [6];
            logic        saw;
            dir_a = '{32'h7FFF, 32'hFFFF, 32'h0003, 32'h8000, 32'h1234, 32'h0000};
            dir_b = '{32'h0001, 32'h0001, 32'h0005, 32'h0001, 32'h5678, 32'h0000};
            dir_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            dir_h = '{0, 0, 0, 0, 10, 0};

            rst_n    = 1'b0;
            in_valid = 1'b0;
            a        = '0;
            b        = '0;
            sub      = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            #1;
            check($sformatf("cfg%0d reset in_ready", g), 64'(in_ready), 64'd1);
            check($sformatf("cfg%0d reset out_valid", g), 64'(out_valid), 64'd0);
            check($sformatf("cfg%0d reset s/cout/ovfl", g), 64'({ovfl, cout, s}), 64'd0);
            @(negedge clk);

            for (int i = 0; i < 6; i++) begin
                issue(W'(dir_a[i]), W'(dir_b[i]), dir_s[i], dir_h[i]);
            end
            drain();

            // Reset two edges into an operation: outputs clear at once, no result follows.
            issue(W'(32'h1234), W'(32'h1111), 1'b0, 0);
            @(posedge clk);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check($sformatf("cfg%0d async reset outputs", g),
                  64'({out_valid, ovfl, cout, s}), 64'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            saw = 1'b0;
            repeat (8) begin
                @(negedge clk);
                #1;
                if (out_valid) saw = 1'b1;
            end
            check($sformatf("cfg%0d no result after reset", g), 64'(saw), 64'd0);
            @(negedge clk);
            issue(W'(32'h0001), W'(32'h0002), 1'b0, 0);
            drain();

            for (int i = 0; i < 1000; i++) begin
                issue(rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 4)));
            end
            drain();
            n_done++;
        end
    end

    initial begin : report
        int guard;
        guard = 0;
        while (n_done < NCFG && guard < 90000) begin
            @(negedge clk);
            guard++;
        end
        if (n_done < NCFG) begin
            check("overall completion", 64'(n_done), 64'(NCFG));
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
